// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared RV32I decode constants: opcodes, operand-forwarding selects,
// CSR serialization FSM states and the in-flight register tracker record.
package riscv_consts;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // Operand select encodings for the ID/EX operand muxes
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    typedef enum logic [1:0] {
        CSR_IDLE  = 2'd0,
        CSR_DRAIN = 2'd1,
        CSR_ISSUE = 2'd2
    } csr_state_e;

    // What the controller remembers about an instruction in EX or WB
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       writes_rd;
        logic       is_load;
    } trk_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage sequencing bus: ID instruction and redirect in, pipeline
// control and forwarding selects out.
interface decode_hazard_ctrl_if;

    logic        id_valid;
    logic [31:0] id_inst;
    logic        ex_redirect;
    logic        id_stall;
    logic        ex_bubble;
    logic        id_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        ex_valid_o;
    logic        wb_valid_o;
    logic        csr_busy;

    // Pipeline side that presents instructions and consumes control
    modport master (
        output id_valid, id_inst, ex_redirect,
        input  id_stall, ex_bubble, id_flush, fwd_a, fwd_b,
               ex_valid_o, wb_valid_o, csr_busy
    );

    // Controller side
    modport slave (
        input  id_valid, id_inst, ex_redirect,
        output id_stall, ex_bubble, id_flush, fwd_a, fwd_b,
               ex_valid_o, wb_valid_o, csr_busy
    );

endinterface

// File: rtl/inst_class_decode.sv
// Opcode-level RV32I instruction classifier shared by the hazard controller
// and the immediate generator.
module inst_class_decode
    import riscv_consts::*;
(
    input  logic [31:0] inst,
    output logic        writes_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_load,
    output logic        is_csr,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    logic wr_raw;
    logic unused_bits;

    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    // Immediate and most funct fields do not affect classification
    assign unused_bits = ^{inst[31:25], inst[13:12]};

    // Classify by opcode; unknown opcodes neither read nor write registers
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        wr_raw   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        is_csr   = 1'b0;
        unique case (inst[6:0])
            OPC_LOAD:   begin wr_raw = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; end
            OPC_OPIMM:  begin wr_raw = 1'b1; uses_rs1 = 1'b1; end
            OPC_OP:     begin wr_raw = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OPC_LUI:    wr_raw = 1'b1;
            OPC_AUIPC:  wr_raw = 1'b1;
            OPC_JAL:    wr_raw = 1'b1;
            OPC_JALR:   begin wr_raw = 1'b1; uses_rs1 = 1'b1; end
            // Immediate CSR forms (funct3[2]=1) carry a zimm, not rs1
            OPC_SYSTEM: begin wr_raw = 1'b1; uses_rs1 = ~inst[14]; is_csr = 1'b1; end
            default: ;
        endcase
    end

    // Writes to x0 are discarded, so they never create a dependency
    assign writes_rd = wr_raw & (rd != 5'd0);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencing for the 3-stage RV32I core: tracks EX/WB
// destinations, resolves RAW hazards by forwarding or stalling, kills ID on
// redirects and drains the pipeline ahead of CSR instructions.
module decode_hazard_ctrl
    import riscv_consts::*;
#(
    parameter bit FWD_EN        = 1'b1,
    parameter bit CSR_SERIALIZE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_hazard_ctrl_if.slave   bus
);

    logic       writes_rd, uses_rs1, uses_rs2, is_load, is_csr;
    logic [4:0] rd, rs1, rs2;

    trk_t       ex_q, wb_q, ex_d;
    csr_state_e state_q;
    logic       busy_q;

    logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
    logic load_use, raw_stall, csr_hold, pipe_busy, stall_int, bubble;

    inst_class_decode u_dec (
        .inst      (bus.id_inst),
        .writes_rd (writes_rd),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .is_load   (is_load),
        .is_csr    (is_csr),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2)
    );

    // Source matches against in-flight producers; x0 is never a dependency
    assign ex_hit_a = bus.id_valid & uses_rs1 & (rs1 != 5'd0) & ex_q.valid & ex_q.writes_rd & (ex_q.rd == rs1);
    assign ex_hit_b = bus.id_valid & uses_rs2 & (rs2 != 5'd0) & ex_q.valid & ex_q.writes_rd & (ex_q.rd == rs2);
    assign wb_hit_a = bus.id_valid & uses_rs1 & (rs1 != 5'd0) & wb_q.valid & wb_q.writes_rd & (wb_q.rd == rs1);
    assign wb_hit_b = bus.id_valid & uses_rs2 & (rs2 != 5'd0) & wb_q.valid & wb_q.writes_rd & (wb_q.rd == rs2);

    // Load data only exists in WB, so a consumer right behind a load waits one cycle
    assign load_use  = ex_q.is_load & (ex_hit_a | ex_hit_b);
    assign raw_stall = !FWD_EN & (ex_hit_a | ex_hit_b | wb_hit_a | wb_hit_b);
    assign pipe_busy = ex_q.valid | wb_q.valid;
    assign csr_hold  = CSR_SERIALIZE &
                       (((state_q == CSR_IDLE) & bus.id_valid & is_csr & pipe_busy) |
                        (state_q == CSR_DRAIN));
    assign stall_int = load_use | raw_stall | csr_hold;

    // A redirect kills ID outright, so it replaces any stall with a flush
    assign bubble        = bus.ex_redirect | stall_int;
    assign bus.ex_bubble = bubble;
    assign bus.id_stall  = stall_int & ~bus.ex_redirect;
    assign bus.id_flush  = bus.ex_redirect;

    assign bus.ex_valid_o = ex_q.valid;
    assign bus.wb_valid_o = wb_q.valid;
    assign bus.csr_busy   = busy_q;

    // Operand selects: EX is the younger producer and wins over WB
    always_comb begin
        bus.fwd_a = FWD_RF;
        bus.fwd_b = FWD_RF;
        if (FWD_EN) begin
            if (ex_hit_a & ~ex_q.is_load) bus.fwd_a = FWD_EX;
            else if (wb_hit_a)            bus.fwd_a = FWD_WB;
            if (ex_hit_b & ~ex_q.is_load) bus.fwd_b = FWD_EX;
            else if (wb_hit_b)            bus.fwd_b = FWD_WB;
        end
    end

    // Record the ID instruction for EX unless it is being held or killed
    always_comb begin
        ex_d.valid     = bus.id_valid & ~bubble;
        ex_d.rd        = rd;
        ex_d.writes_rd = writes_rd;
        ex_d.is_load   = is_load;
    end

    // Advance the EX/WB trackers every cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update from pre-edge values regardless of statement order.
        if (rst) begin
            ex_q <= '0;
            wb_q <= '0;
        end else begin
            ex_q <= ex_d;
            wb_q <= ex_q;
        end
    end

    // CSR drain FSM: hold the CSR in ID until EX and WB are empty, then issue it
    always_ff @(posedge clk) begin
        if (rst || bus.ex_redirect) begin
            state_q <= CSR_IDLE;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                CSR_IDLE: begin
                    // An outstanding load-use stall resolves before draining starts
                    if (CSR_SERIALIZE && bus.id_valid && is_csr && pipe_busy && !load_use) begin
                        state_q <= CSR_DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                CSR_DRAIN: begin
                    if (!pipe_busy) state_q <= CSR_ISSUE;
                end
                CSR_ISSUE: begin
                    state_q <= CSR_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= CSR_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed-vector bench for decode_hazard_ctrl: load-use, forwarding, x0,
// CSR drain, redirect and reset-during-drain sequences.
module tb_decode_hazard_ctrl;

    localparam logic [31:0] NOP       = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] LW_X5     = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD_X6    = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] ADDI_X3   = 32'h0010_0193; // addi x3,x0,1
    localparam logic [31:0] SUB_X4    = 32'h4031_8233; // sub  x4,x3,x3
    localparam logic [31:0] OR_X7     = 32'h0001_E3B3; // or   x7,x3,x0
    localparam logic [31:0] ADDI_X0   = 32'h0050_0013; // addi x0,x0,5
    localparam logic [31:0] ADD_X1_00 = 32'h0000_00B3; // add  x1,x0,x0
    localparam logic [31:0] CSRRW     = 32'h51E0_9073; // csrrw x0,0x51e,x1

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decode_hazard_ctrl_if dif ();

    decode_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge; return at the falling edge
    task automatic cyc(input logic r, input logic v, input logic [31:0] inst, input logic redir);
        @(posedge clk);
        #1;
        rst             = r;
        dif.id_valid    = v;
        dif.id_inst     = inst;
        dif.ex_redirect = redir;
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string tag, input logic stall, input logic bub,
                           input logic flush, input logic [1:0] fa, input logic [1:0] fb);
        check({tag, ".stall"},  dif.id_stall,  stall);
        check({tag, ".bubble"}, dif.ex_bubble, bub);
        check({tag, ".flush"},  dif.id_flush,  flush);
        check({tag, ".fwd_a"},  dif.fwd_a,     fa);
        check({tag, ".fwd_b"},  dif.fwd_b,     fb);
    endtask

    task automatic idle2();
        cyc(1'b0, 1'b0, NOP, 1'b0);
        cyc(1'b0, 1'b0, NOP, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        dif.id_valid = 1'b0;
        dif.id_inst = NOP;
        dif.ex_redirect = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, NOP, 1'b0);
        cyc(1'b1, 1'b0, NOP, 1'b0);
        chk_ctl("rst", 0, 0, 0, 0, 0);
        check("rst.ex_valid", dif.ex_valid_o, 1'b0);
        check("rst.wb_valid", dif.wb_valid_o, 1'b0);
        check("rst.csr_busy", dif.csr_busy, 1'b0);
        idle2();

        // Load-use: one stall cycle, then forward from WB
        cyc(1'b0, 1'b1, LW_X5, 1'b0);
        check("lu0.stall", dif.id_stall, 1'b0);
        cyc(1'b0, 1'b1, ADD_X6, 1'b0);
        check("lu1.stall", dif.id_stall, 1'b1);
        check("lu1.bubble", dif.ex_bubble, 1'b1);
        cyc(1'b0, 1'b1, ADD_X6, 1'b0);
        chk_ctl("lu2", 0, 0, 0, 2'd2, 2'd0);
        idle2();

        // ALU chain: EX forwarding on both operands, then WB
        cyc(1'b0, 1'b1, ADDI_X3, 1'b0);
        cyc(1'b0, 1'b1, SUB_X4, 1'b0);
        chk_ctl("fwd_ex", 0, 0, 0, 2'd1, 2'd1);
        cyc(1'b0, 1'b1, OR_X7, 1'b0);
        chk_ctl("fwd_wb", 0, 0, 0, 2'd2, 2'd0);
        idle2();

        // Invalid ID never forwards even when the registers match
        cyc(1'b0, 1'b1, ADDI_X3, 1'b0);
        cyc(1'b0, 1'b0, SUB_X4, 1'b0);
        chk_ctl("inv", 0, 0, 0, 2'd0, 2'd0);
        idle2();

        // x0 is never forwarded
        cyc(1'b0, 1'b1, ADDI_X0, 1'b0);
        cyc(1'b0, 1'b1, ADD_X1_00, 1'b0);
        chk_ctl("x0", 0, 0, 0, 2'd0, 2'd0);
        idle2();

        // CSR with EX and WB occupied: stall, two DRAIN cycles, ISSUE, IDLE
        cyc(1'b0, 1'b1, NOP, 1'b0);
        cyc(1'b0, 1'b1, NOP, 1'b0);
        cyc(1'b0, 1'b1, CSRRW, 1'b0);
        chk_ctl("csr0", 1, 1, 0, 2'd0, 2'd0);
        check("csr0.busy", dif.csr_busy, 1'b0);
        cyc(1'b0, 1'b1, CSRRW, 1'b0);
        check("csr1.busy", dif.csr_busy, 1'b1);
        check("csr1.stall", dif.id_stall, 1'b1);
        cyc(1'b0, 1'b1, CSRRW, 1'b0);
        check("csr2.busy", dif.csr_busy, 1'b1);
        check("csr2.stall", dif.id_stall, 1'b1);
        check("csr2.wb_valid", dif.wb_valid_o, 1'b0);
        cyc(1'b0, 1'b1, CSRRW, 1'b0);
        chk_ctl("csr3", 0, 0, 0, 2'd0, 2'd0);
        check("csr3.busy", dif.csr_busy, 1'b1);
        cyc(1'b0, 1'b0, NOP, 1'b0);
        check("csr4.busy", dif.csr_busy, 1'b0);
        check("csr4.ex_valid", dif.ex_valid_o, 1'b1);
        idle2();

        // Redirect overrides a load-use stall; the next instruction proceeds
        cyc(1'b0, 1'b1, LW_X5, 1'b0);
        cyc(1'b0, 1'b1, ADD_X6, 1'b1);
        chk_ctl("redir", 0, 1, 1, 2'd0, 2'd0);
        cyc(1'b0, 1'b1, OR_X7, 1'b0);
        chk_ctl("post_redir", 0, 0, 0, 2'd0, 2'd0);
        check("post_redir.ex_valid", dif.ex_valid_o, 1'b0);
        check("post_redir.wb_valid", dif.wb_valid_o, 1'b1);
        cyc(1'b0, 1'b0, NOP, 1'b0);
        check("post_redir2.ex_valid", dif.ex_valid_o, 1'b1);
        idle2();

        // Reset asserted during DRAIN aborts to IDLE with empty trackers
        cyc(1'b0, 1'b1, NOP, 1'b0);
        cyc(1'b0, 1'b1, NOP, 1'b0);
        cyc(1'b0, 1'b1, CSRRW, 1'b0);
        cyc(1'b0, 1'b1, CSRRW, 1'b0);
        check("drain.busy", dif.csr_busy, 1'b1);
        cyc(1'b1, 1'b1, CSRRW, 1'b0);
        cyc(1'b1, 1'b1, CSRRW, 1'b0);
        chk_ctl("drain_rst", 0, 0, 0, 2'd0, 2'd0);
        check("drain_rst.busy", dif.csr_busy, 1'b0);
        check("drain_rst.ex_valid", dif.ex_valid_o, 1'b0);
        check("drain_rst.wb_valid", dif.wb_valid_o, 1'b0);
        idle2();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
